// File: rtl/msg_build_arbiter.sv
// Round-robin arbiter sharing one message_build padding engine between NUM_REQ requesters.
// A grant covers one config handshake plus ceil(size/512) data words (minimum one).
module msg_build_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   sync_rst,
   input  logic [NUM_REQ*64-1:0]  req_cfg_size,
   input  logic [NUM_REQ*2-1:0]   req_cfg_scheme,
   input  logic [NUM_REQ-1:0]     req_cfg_valid,
   output logic [NUM_REQ-1:0]     req_cfg_ready,
   input  logic [NUM_REQ*512-1:0] req_data,
   input  logic [NUM_REQ-1:0]     req_data_last,
   input  logic [NUM_REQ-1:0]     req_data_valid,
   output logic [NUM_REQ-1:0]     req_data_ready,
   output logic [63:0]            cfg_size,
   output logic [1:0]             cfg_scheme,
   output logic                   cfg_valid,
   input  logic                   cfg_ready,
   output logic [511:0]           data_out,
   output logic                   data_out_last,
   output logic                   data_out_valid,
   input  logic                   data_out_ready,
   output logic [ID_W-1:0]        grant_id,
   output logic                   grant_active,
   output logic                   err_last
);

   typedef enum logic [1:0] {S_IDLE, S_CFG, S_DATA} state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   logic [54:0]     word_cnt_q, word_cnt_d;
   logic [63:0]     cfg_size_q, cfg_size_d;
   logic [1:0]      cfg_scheme_q, cfg_scheme_d;
   logic            grant_active_q, grant_active_d;
   logic            err_last_q, err_last_d;

   logic [63:0]     size_arr   [NUM_REQ];
   logic [1:0]      scheme_arr [NUM_REQ];
   logic [511:0]    data_arr   [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign size_arr[i]   = req_cfg_size[64*i +: 64];
      assign scheme_arr[i] = req_cfg_scheme[2*i +: 2];
      assign data_arr[i]   = req_data[512*i +: 512];
   end

   logic [ID_W-1:0] sel;
   logic [ID_W-1:0] cand;
   logic            sel_found;
   logic [54:0]     cnt_raw;
   logic            last_word;

   // First valid channel at or above rr_ptr, wrapping around.
   always_comb begin
      sel       = '0;
      cand      = '0;
      sel_found = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!sel_found && req_cfg_valid[cand]) begin
            sel_found = 1'b1;
            sel       = cand;
         end
      end
   end

   assign cnt_raw   = size_arr[sel][63:9] + 55'(|size_arr[sel][8:0]);
   assign last_word = (word_cnt_q == 55'd1);

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      grant_id_d     = grant_id_q;
      word_cnt_d     = word_cnt_q;
      cfg_size_d     = cfg_size_q;
      cfg_scheme_d   = cfg_scheme_q;
      grant_active_d = grant_active_q;
      err_last_d     = err_last_q;
      req_cfg_ready  = '0;
      req_data_ready = '0;
      data_out       = '0;
      data_out_valid = 1'b0;
      data_out_last  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               req_cfg_ready[sel] = 1'b1;
               cfg_size_d         = size_arr[sel];
               cfg_scheme_d       = scheme_arr[sel];
               grant_id_d         = sel;
               grant_active_d     = 1'b1;
               rr_ptr_d           = ID_W'((32'(sel) + 32'd1) % NUM_REQ);
               word_cnt_d         = (cnt_raw == '0) ? 55'd1 : cnt_raw;
               state_d            = S_CFG;
            end
         end
         S_CFG: begin
            if (cfg_ready) state_d = S_DATA;
         end
         S_DATA: begin
            data_out                   = data_arr[grant_id_q];
            data_out_valid             = req_data_valid[grant_id_q];
            data_out_last              = last_word;
            req_data_ready[grant_id_q] = data_out_ready;
            if (req_data_valid[grant_id_q] && data_out_ready) begin
               word_cnt_d = word_cnt_q - 55'd1;
               if (req_data_last[grant_id_q] != last_word) err_last_d = 1'b1;
               if (last_word) begin
                  state_d        = S_IDLE;
                  grant_active_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q        <= S_IDLE;
         rr_ptr_q       <= '0;
         grant_id_q     <= '0;
         word_cnt_q     <= '0;
         cfg_size_q     <= '0;
         cfg_scheme_q   <= '0;
         grant_active_q <= 1'b0;
         err_last_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         grant_id_q     <= grant_id_d;
         word_cnt_q     <= word_cnt_d;
         cfg_size_q     <= cfg_size_d;
         cfg_scheme_q   <= cfg_scheme_d;
         grant_active_q <= grant_active_d;
         err_last_q     <= err_last_d;
      end
   end

   assign cfg_valid    = (state_q == S_CFG);
   assign cfg_size     = cfg_size_q;
   assign cfg_scheme   = cfg_scheme_q;
   assign grant_id     = grant_id_q;
   assign grant_active = grant_active_q;
   assign err_last     = err_last_q;

endmodule
